vga_mem_responder: RTL and testbench

//  Memory-side responder for the vga scanout engine's fetch interface, on the system clock domain.

---
 rtl/vga_mem_responder_pkg.sv | 13 +
 rtl/vga_mem_responder_if.sv | 22 ++
 rtl/vga_mem_responder_offset_reg.sv | 25 ++
 rtl/vga_mem_responder.sv | 62 ++++++
 tb/tb_vga_mem_responder.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/vga_mem_responder_pkg.sv
// vga_mem_responder_pkg: shared widths, FSM encoding and address helper for the vga memory responder
package vga_mem_responder_pkg;
  localparam int VGA_AW = 20;
  localparam int MEM_AW = VGA_AW + 2;
  localparam int MEM_DW = 16;
  localparam int BEATS = 3;
  localparam int VGA_DW = MEM_DW * BEATS;
  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);
  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
  function automatic logic [MEM_AW-1:0] beat0_addr(input logic [VGA_AW-1:0] a);
    return {a, 2'b00};
  endfunction
endpackage

// File: rtl/vga_mem_responder_if.sv
// vga_mem_responder_if: vga fetch/offset bus and memory read port seen by the responder
interface vga_mem_responder_if;
  import vga_mem_responder_pkg::*;
  logic [VGA_AW-1:0] vga_addr;
  logic              vga_sel;
  logic [VGA_DW-1:0] vga_data;
  logic              vga_valid;
  logic              vga_offset_sel;
  logic [VGA_AW-1:0] vga_offset_in;
  logic              mem_req;
  logic [MEM_AW-1:0] mem_addr;
  logic [MEM_DW-1:0] mem_rdata;
  logic              mem_ack;
  modport slave (
    input  vga_addr, vga_sel, vga_offset_sel, mem_rdata, mem_ack,
    output vga_data, vga_valid, vga_offset_in, mem_req, mem_addr
  );
  modport master (
    output vga_addr, vga_sel, vga_offset_sel, mem_rdata, mem_ack,
    input  vga_data, vga_valid, vga_offset_in, mem_req, mem_addr
  );
endinterface

// File: rtl/vga_mem_responder_offset_reg.sv
// vga_mem_responder_offset_reg: CPU shadow offset published at frame start, with write-through
module vga_mem_responder_offset_reg
  import vga_mem_responder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [VGA_AW-1:0] wdata,
  input  logic              publish,
  output logic [VGA_AW-1:0] offset
);
  logic [VGA_AW-1:0] shadow;
  logic [VGA_AW-1:0] next_shadow;
  assign next_shadow = we ? wdata : shadow;
  // shadow tracks CPU writes; publish copies the post-write value so a same-cycle write goes straight through
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      offset <= '0;
    end else begin
      shadow <= next_shadow;
      if (publish) offset <= next_shadow;
    end
  end
endmodule

// File: rtl/vga_mem_responder.sv
// vga_mem_responder: serves vga fetches with three 16-bit memory reads and holds the frame offset
module vga_mem_responder
  import vga_mem_responder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              off_we,
  input  logic [VGA_AW-1:0] off_wdata,
  vga_mem_responder_if.slave bus
);
  state_t state, nxt;
  logic [1:0] k;
  logic [2*MEM_DW-1:0] part;
  // state register; async reset drops mem_req at once so a late ack lands in IDLE and is ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  // next state: a dropped vga_sel aborts only after the in-flight beat is acknowledged
  always_comb begin
    nxt = state;
    nxt = (state == IDLE)  ? (bus.vga_sel ? FETCH : IDLE) :
          (state == FETCH) ? (!bus.mem_ack ? FETCH : !bus.vga_sel ? IDLE : (k == LAST_BEAT) ? DONE : FETCH) :
                             (bus.vga_sel ? DONE : IDLE);
  end
  // outputs decoded from state so request and valid are glitch-free registered levels
  always_comb begin
    bus.mem_req = 1'b0;
    bus.vga_valid = 1'b0;
    bus.mem_req = (state == FETCH);
    bus.vga_valid = (state == DONE);
  end
  // address latch, beat counter and data assembly; vga_data only changes on a completed burst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k <= '0;
      part <= '0;
      bus.mem_addr <= '0;
      bus.vga_data <= '0;
    end else if (state == IDLE && bus.vga_sel) begin
      k <= '0;
      bus.mem_addr <= beat0_addr(bus.vga_addr);
    end else if (state == FETCH && bus.mem_ack && bus.vga_sel) begin
      if (k == LAST_BEAT) begin
        bus.vga_data <= {bus.mem_rdata, part};
      end else begin
        if (k[0]) part[2*MEM_DW-1:MEM_DW] <= bus.mem_rdata;
        else part[MEM_DW-1:0] <= bus.mem_rdata;
        k <= k + 2'd1;
        bus.mem_addr <= bus.mem_addr + 1'b1;
      end
    end
  end
  vga_mem_responder_offset_reg u_offset (
    .clk(clk),
    .rst(rst),
    .we(off_we),
    .wdata(off_wdata),
    .publish(bus.vga_offset_sel),
    .offset(bus.vga_offset_in)
  );
endmodule

// File: tb/tb_vga_mem_responder.sv
// tb_vga_mem_responder: table, random and corner-case checks of the vga memory responder
module tb_vga_mem_responder;
  import vga_mem_responder_pkg::*;
  typedef struct {
    logic [19:0] va;
    int          w;
    logic [15:0] k;
    logic [47:0] d;
    int          lat;
  } vec_t;
  logic clk = 0;
  logic rst = 1;
  logic off_we = 0;
  logic [19:0] off_wdata = 0;
  int checks = 0;
  int errors = 0;
  int waits = 0;
  int wcnt = 0;
  logic [15:0] key = 0;
  logic [21:0] acked[$];
  logic [19:0] sh, pub;
  logic [47:0] last_exp;
  vec_t vt[4];
  vga_mem_responder_if bus();
  vga_mem_responder dut (.clk(clk), .rst(rst), .off_we(off_we), .off_wdata(off_wdata), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [21:0] a);
    return a[15:0] ^ key;
  endfunction

  function automatic logic [47:0] model_data(input logic [19:0] va, input logic [15:0] kk);
    logic [47:0] d = 0;
    int base = int'(va) * 4;
    for (int b = 0; b < 3; b++) d = d | (48'(((base + b) % 65536) ^ int'(kk)) << (16 * b));
    return d;
  endfunction

  always @(negedge clk) begin
    if (bus.mem_req) begin
      bus.mem_ack = (wcnt == waits);
      bus.mem_rdata = bus.mem_ack ? mem_word(bus.mem_addr) : 16'hDEAD;
      wcnt = bus.mem_ack ? 0 : wcnt + 1;
    end else begin
      bus.mem_ack = 0;
      wcnt = 0;
    end
  end

  always @(posedge clk) if (!rst && bus.mem_req && bus.mem_ack) acked.push_back(bus.mem_addr);

  task automatic fetch(input logic [19:0] va, input int w, input logic [15:0] kk, input logic [47:0] ed, input int el, input string tag);
    logic [21:0] a;
    logic [47:0] d;
    int n = 0;
    int reqs = 0;
    waits = w;
    key = kk;
    acked.delete();
    a = {va, 2'b00};
    bus.vga_addr = va;
    bus.vga_sel = 1;
    while (n < 200) begin
      @(posedge clk); #1;
      n++;
      if (bus.vga_valid) break;
      if (bus.mem_req) reqs++;
      bus.vga_addr = 20'($urandom);
    end
    chk({tag, "_latency"}, 64'(n), 64'(el));
    chk({tag, "_req_cycles"}, 64'(reqs), 64'(3 * (w + 1)));
    chk({tag, "_data"}, 64'(bus.vga_data), 64'(ed));
    chk({tag, "_beats"}, 64'(acked.size()), 64'd3);
    for (int i = 0; i < 3 && i < acked.size(); i++) chk({tag, "_addr"}, 64'(acked[i]), 64'(a + 22'(i)));
    d = bus.vga_data;
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_valid_hold"}, 64'(bus.vga_valid), 64'd1);
    chk({tag, "_data_hold"}, 64'(bus.vga_data), 64'(d));
    bus.vga_sel = 0;
    @(posedge clk); #1;
    chk({tag, "_valid_drop"}, 64'(bus.vga_valid), 64'd0);
    last_exp = ed;
  endtask

  task automatic off_cycle(input logic we, input logic sel, input logic [19:0] wd);
    off_we = we;
    off_wdata = wd;
    bus.vga_offset_sel = sel;
    @(posedge clk); #1;
    if (sel) pub = we ? wd : sh;
    if (we) sh = wd;
    off_we = 0;
    bus.vga_offset_sel = 0;
  endtask

  initial begin
    int n;
    int seen;
    logic [19:0] va;
    logic [15:0] kk;
    int w;
    vt[0] = '{20'h00010, 0, 16'h0000, 48'h004200410040, 4};
    vt[1] = '{20'h12345, 2, 16'h0000, 48'h8D168D158D14, 10};
    vt[2] = '{20'hFFFFF, 0, 16'h0000, 48'hFFFEFFFDFFFC, 4};
    vt[3] = '{20'h0ABCD, 1, 16'h5A5A, 48'hF56CF56FF56E, 7};
    bus.vga_addr = 0;
    bus.vga_sel = 0;
    bus.vga_offset_sel = 0;
    sh = 0;
    pub = 0;
    #12;
    chk("rst_mem_req", 64'(bus.mem_req), 0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 0);
    chk("rst_valid", 64'(bus.vga_valid), 0);
    chk("rst_data", 64'(bus.vga_data), 0);
    chk("rst_offset", 64'(bus.vga_offset_in), 0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) fetch(vt[i].va, vt[i].w, vt[i].k, vt[i].d, vt[i].lat, $sformatf("vec%0d", i));
    for (int i = 0; i < 20; i++) begin
      va = 20'($urandom);
      w = int'($urandom_range(0, 3));
      kk = 16'($urandom);
      fetch(va, w, kk, model_data(va, kk), 3 * (w + 1) + 1, $sformatf("rnd%0d", i));
    end
    waits = 2;
    key = 0;
    acked.delete();
    bus.vga_addr = 20'h00100;
    bus.vga_sel = 1;
    n = 0;
    while (acked.size() < 1 && n < 50) begin @(posedge clk); #1; n++; end
    bus.vga_sel = 0;
    n = 0;
    seen = 0;
    while (bus.mem_req && n < 50) begin @(posedge clk); #1; n++; if (bus.vga_valid) seen = 1; end
    chk("drop_beats", 64'(acked.size()), 64'd2);
    if (acked.size() == 2) chk("drop_addr", 64'(acked[1]), 64'h401);
    chk("drop_req", 64'(bus.mem_req), 0);
    repeat (6) begin @(posedge clk); #1; if (bus.vga_valid) seen = 1; end
    chk("drop_valid", 64'(seen), 0);
    chk("drop_data", 64'(bus.vga_data), 64'(last_exp));
    fetch(20'h00100, 0, 16'h1234, model_data(20'h00100, 16'h1234), 4, "after_drop");
    off_cycle(1, 0, 20'h12345);
    chk("off_write_only", 64'(bus.vga_offset_in), 64'(pub));
    off_cycle(0, 1, 20'h0);
    chk("off_publish", 64'(bus.vga_offset_in), 64'h12345);
    off_cycle(1, 1, 20'h0ABCD);
    chk("off_write_through", 64'(bus.vga_offset_in), 64'h0ABCD);
    for (int i = 0; i < 30; i++) begin
      off_cycle(1'($urandom), 1'($urandom), 20'($urandom));
      chk("off_rnd", 64'(bus.vga_offset_in), 64'(pub));
    end
    off_cycle(1, 0, 20'h55555);
    waits = 2;
    acked.delete();
    bus.vga_addr = 20'h00200;
    bus.vga_sel = 1;
    n = 0;
    while (acked.size() < 1 && n < 50) begin @(posedge clk); #1; n++; end
    #2;
    rst = 1;
    #1;
    chk("midrst_mem_req", 64'(bus.mem_req), 0);
    chk("midrst_mem_addr", 64'(bus.mem_addr), 0);
    chk("midrst_valid", 64'(bus.vga_valid), 0);
    chk("midrst_data", 64'(bus.vga_data), 0);
    chk("midrst_offset", 64'(bus.vga_offset_in), 0);
    bus.vga_sel = 0;
    @(posedge clk); #1;
    rst = 0;
    sh = 0;
    pub = 0;
    @(posedge clk); #1;
    off_cycle(0, 1, 20'h0);
    chk("midrst_shadow", 64'(bus.vga_offset_in), 0);
    fetch(20'h00200, 2, 16'hA5A5, model_data(20'h00200, 16'hA5A5), 10, "after_rst");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
